sys_reset_sequencer: RTL and testbench

Sits directly downstream of the ROACH clock infrastructure block and consumes its sys_clk, sys_clk_lock and idelay_rdy outputs. It drives that block's idelay_rst input, so this block generates the IDELAYCTRL reset pulse. It also produces the design-wide synchronous system reset, released only after the clock is stable and the IDELAY controller is ready. It monitors lock and ready continuously and re-sequences whenever either is lost.

---
 rtl/sys_reset_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sys_reset_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_reset_sequencer.sv
// Reset sequencer: waits for stable MMCM lock, pulses idelay_rst until idelay_rdy, holds sys_rst, then RUN.
// Optional lock-loss event counter built only when SYS_RESET_SEQ_LOCK_LOSS_CNT_EN is defined.
module sys_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int IDELAY_RST_CYCLES  = 16,
    parameter int RDY_TIMEOUT        = 4096,
    parameter int RST_HOLD_CYCLES    = 64,
    parameter int CNT_W              = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       sys_clk_lock,
    input  logic       idelay_rdy,
    output logic       idelay_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_LOCK_STABLE = 3'd1,
        ST_IDLY_RST    = 3'd2,
        ST_IDLY_WAIT   = 3'd3,
        ST_RST_HOLD    = 3'd4,
        ST_RUN         = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LS_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IR_LOAD = CNT_W'(IDELAY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RH_LOAD = CNT_W'(RST_HOLD_CYCLES - 1);

    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q, lock_s_d;
    logic             rdy_meta_q, rdy_meta_d;
    logic             rdy_s_q, rdy_s_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             idelay_rst_q, idelay_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;

    always_comb begin
        lock_meta_d = sys_clk_lock;
        lock_s_d    = lock_meta_q;
        rdy_meta_d  = idelay_rdy;
        rdy_s_d     = rdy_meta_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        // Losing lock overrides every other transition, aborting any idelay_rst pulse.
        if (state_q != ST_WAIT_LOCK && !lock_s_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = ST_LOCK_STABLE;
                        cnt_d   = LS_LOAD;
                    end
                end
                ST_LOCK_STABLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLY_RST;
                        cnt_d   = IR_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_IDLY_RST: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLY_WAIT;
                        cnt_d   = TO_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_IDLY_WAIT: begin
                    // Ready on the expiry cycle still counts as success.
                    if (rdy_s_q) begin
                        state_d = ST_RST_HOLD;
                        cnt_d   = RH_LOAD;
                    end else if (cnt_q == '0) begin
                        state_d = ST_IDLY_RST;
                        cnt_d   = IR_LOAD;
                        if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_RST_HOLD: begin
                    if (!rdy_s_q) begin
                        state_d = ST_IDLY_RST;
                        cnt_d   = IR_LOAD;
                    end else if (cnt_q == '0) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!rdy_s_q) begin
                        state_d = ST_IDLY_RST;
                        cnt_d   = IR_LOAD;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
        // Outputs decode the next state so they register on the same edge as the state.
        idelay_rst_d = (state_d == ST_IDLY_RST);
        sys_rst_d    = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            rdy_meta_q   <= 1'b0;
            rdy_s_q      <= 1'b0;
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            retry_q      <= 4'd0;
            idelay_rst_q <= 1'b0;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            lock_meta_q  <= lock_meta_d;
            lock_s_q     <= lock_s_d;
            rdy_meta_q   <= rdy_meta_d;
            rdy_s_q      <= rdy_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            idelay_rst_q <= idelay_rst_d;
            sys_rst_q    <= sys_rst_d;
            ready_q      <= ready_d;
        end
    end

`ifdef SYS_RESET_SEQ_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt_q, lock_loss_cnt_d;
    logic       lock_lost;

    always_comb begin
        lock_lost       = (state_q != ST_WAIT_LOCK) && !lock_s_q;
        lock_loss_cnt_d = lock_loss_cnt_q;
        if (lock_lost && lock_loss_cnt_q != 8'hFF) lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) lock_loss_cnt_q <= 8'd0;
        else     lock_loss_cnt_q <= lock_loss_cnt_d;
    end

    assign lock_loss_cnt = lock_loss_cnt_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

    assign idelay_rst = idelay_rst_q;
    assign sys_rst    = sys_rst_q;
    assign ready      = ready_q;
    assign state      = state_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Directed bench for sys_reset_sequencer with shortened timing parameters.
module tb_sys_reset_sequencer;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       sys_clk_lock = 1'b0;
    logic       idelay_rdy = 1'b0;
    logic       idelay_rst;
    logic       sys_rst;
    logic       ready;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int tests = 0;
    int fails = 0;
    int exp_llc;

    always #5 sys_clk = ~sys_clk;

    sys_reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .IDELAY_RST_CYCLES (4),
        .RDY_TIMEOUT       (32),
        .RST_HOLD_CYCLES   (6),
        .CNT_W             (16)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .sys_clk_lock (sys_clk_lock),
        .idelay_rdy   (idelay_rdy),
        .idelay_rst   (idelay_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .state        (state),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sys_clk_lock = 1'b0;
        idelay_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int n_ls;
        int n_hold;
        int hi_seen;
        int prev_sys_rst;

        // Reset values
        do_reset();
        rst = 1'b1;
        #1;
        check("rst_idelay_rst", idelay_rst, 0);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_state", state, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_llc", lock_loss_cnt, 0);

        // Nominal bring-up: 2 sync + 1 entry + 8 stable cycles before IDLY_RST
        tick();
        rst = 1'b0;
        sys_clk_lock = 1'b1;
        n = 0; n_ls = 0;
        while (state != 3'd2 && n < 100) begin
            tick();
            n++;
            if (state == 3'd1) n_ls++;
        end
        check("nom_ticks_to_idly_rst", n, 11);
        check("nom_lock_stable_cycles", n_ls, 8);
        check("nom_idelay_rst_rise", idelay_rst, 1);
        n = 0;
        while (idelay_rst && n < 50) begin
            n++;
            tick();
        end
        check("nom_idelay_rst_width", n, 4);
        check("nom_state_idly_wait", state, 3);
        repeat (10) tick();
        idelay_rdy = 1'b1;
        n = 0; n_hold = 0; prev_sys_rst = 1;
        while (!ready && n < 100) begin
            prev_sys_rst = sys_rst;
            tick();
            n++;
            if (state == 3'd4) n_hold++;
        end
        check("nom_ticks_rdy_to_ready", n, 9);
        check("nom_hold_cycles", n_hold, 6);
        check("nom_sys_rst_prev_high", prev_sys_rst, 1);
        check("nom_sys_rst_low_with_ready", sys_rst, 0);
        check("nom_state_run", state, 5);
        check("nom_retry", retry_cnt, 0);

        // Lock loss in RUN: outputs react one cycle after lock_s falls
        sys_clk_lock = 1'b0;
        tick();
        tick();
        check("ll_state_before", state, 5);
        check("ll_ready_before", ready, 1);
        tick();
        check("ll_state", state, 0);
        check("ll_sys_rst", sys_rst, 1);
        check("ll_ready", ready, 0);
`ifdef SYS_RESET_SEQ_LOCK_LOSS_CNT_EN
        exp_llc = 1;
`else
        exp_llc = 0;
`endif
        check("ll_llc", lock_loss_cnt, exp_llc);

        // Recover, then drop idelay_rdy in RUN with lock held
        sys_clk_lock = 1'b1;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        check("rec_ready", ready, 1);
        idelay_rdy = 1'b0;
        tick();
        tick();
        check("rd_state_before", state, 5);
        tick();
        check("rd_state", state, 2);
        check("rd_sys_rst", sys_rst, 1);
        check("rd_ready", ready, 0);
        n = 0;
        while (idelay_rst && n < 50) begin
            n++;
            tick();
        end
        check("rd_idelay_rst_width", n, 4);
        idelay_rdy = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check("rd_recovered", ready, 1);
        check("rd_sys_rst_low", sys_rst, 0);
        check("rd_retry", retry_cnt, 0);
        check("rd_llc", lock_loss_cnt, exp_llc);

        // Lock glitch during LOCK_STABLE after 5 stable cycles
        do_reset();
        sys_clk_lock = 1'b1;
        n = 0;
        while (state != 3'd1 && n < 20) begin
            tick();
            n++;
        end
        check("gl_enter_ls", state, 1);
        repeat (4) tick();
        sys_clk_lock = 1'b0;
        hi_seen = 0;
        repeat (3) begin
            tick();
            if (idelay_rst) hi_seen = 1;
        end
        check("gl_state_back", state, 0);
        check("gl_no_pulse", hi_seen, 0);
        sys_clk_lock = 1'b1;
        n = 0; n_ls = 0;
        while (state != 3'd2 && n < 100) begin
            tick();
            n++;
            if (state == 3'd1) n_ls++;
        end
        check("gl_ticks_to_idly_rst", n, 11);
        check("gl_full_stable", n_ls, 8);

        // idelay_rdy never rises: retry every 36 cycles, saturating at 15
        do_reset();
        sys_clk_lock = 1'b1;
        n = 0;
        while (!idelay_rst && n < 50) begin
            tick();
            n++;
        end
        check("to_first_pulse", idelay_rst, 1);
        check("to_retry0", retry_cnt, 0);
        for (int i = 1; i <= 17; i++) begin
            n = 0;
            while (idelay_rst && n < 100) begin
                tick();
                n++;
            end
            while (!idelay_rst && n < 100) begin
                tick();
                n++;
            end
            if (i <= 3 || i == 17) check($sformatf("to_period_%0d", i), n, 36);
            check($sformatf("to_retry_%0d", i), retry_cnt, (i > 15) ? 15 : i);
            check($sformatf("to_ready_%0d", i), ready, 0);
        end

        // Asynchronous rst in the middle of an idelay_rst pulse
        tick();
        check("ar_in_pulse", idelay_rst, 1);
        rst = 1'b1;
        #1;
        check("ar_idelay_rst", idelay_rst, 0);
        check("ar_sys_rst", sys_rst, 1);
        check("ar_state", state, 0);
        check("ar_retry", retry_cnt, 0);
        check("ar_llc", lock_loss_cnt, 0);
        check("ar_ready", ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
